// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: WIDTH cycles per add, LSB first, one shared 1-bit add cell.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds input port sub).
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_s_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_sub;
    logic             w_bit;
    logic             w_carry;
    logic [WIDTH-1:0] w_s_next;
    logic             w_last;

    // Two half-adder stages; the carry OR merges their generate terms.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        logic [1:0] ha0;
        logic [1:0] ha1;
        ha0 = half_add(x, y);
        ha1 = half_add(ha0[0], c);
        return {ha0[1] | ha1[1], ha1[0]};
    endfunction

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    assign {w_carry, w_bit} = full_add(r_a_sh[0], r_b_sh[0], r_carry);
    assign w_s_next         = {w_bit, r_s_sh};
    assign w_last           = (r_cnt == CNT_W'(WIDTH - 1));

    assign s    = r_s;
    assign cout = r_cout;
    assign busy = r_busy;
    assign done = r_done;

    // Sequencer FSM with shifters, carry, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_sh  <= {WIDTH{1'b0}};
            r_b_sh  <= {WIDTH{1'b0}};
            r_s_sh  <= {(WIDTH-1){1'b0}};
            r_carry <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
            r_s     <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b ^ {WIDTH{w_sub}};
                        r_carry <= w_sub;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_s_sh  <= w_s_next[WIDTH-1:1];
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_s     <= w_s_next;
                        r_cout  <= w_carry;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
